// File: rtl/comparador_der_izq_serial_if.sv
// Operand/result bundle for the serial right-to-left magnitude comparator.
interface comparador_der_izq_serial_if #(
  parameter int unsigned N = 8
);
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic         p_o;
  logic         q_o;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, p_o, q_o
  );

  // Comparator side.
  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, p_o, q_o
  );
endinterface

// File: rtl/comparador_der_izq_serial.sv
// Serial magnitude comparator: scans A and B LSB first, one bit pair per clock.
// The most significant unequal pair decides, giving P/Q = 10 (A>B), 01 (A<B), 00 (equal).
module comparador_der_izq_serial #(
  parameter int unsigned N = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  comparador_der_izq_serial_if.slave   bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d;
  logic [N-1:0]  sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pqs_q, pqs_d;
  logic          p_q, p_d;
  logic          q_q, q_d;
  logic          busy_q, done_q;
  logic [1:0]    pq_upd;

  // Partial-state update for the current bit pair; a later (higher) unequal pair overrides.
  always_comb begin
    pq_upd = pqs_q;
    unique case ({sa_q[0], sb_q[0]})
      2'b10:   pq_upd = 2'b10;
      2'b01:   pq_upd = 2'b01;
      default: pq_upd = pqs_q;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    pqs_d   = pqs_q;
    p_d     = p_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          sa_d    = bus.a_i;
          sb_d    = bus.b_i;
          pqs_d   = 2'b00;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pqs_d = pq_upd;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          // Decode rather than copy so a corrupted 11 never reaches the outputs.
          p_d = (pq_upd == 2'b10);
          q_d = (pq_upd == 2'b01);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      pqs_q   <= 2'b00;
      p_q     <= 1'b0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      pqs_q   <= pqs_d;
      p_q     <= p_d;
      q_q     <= q_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.p_o    = p_q;
  assign bus.q_o    = q_q;
endmodule

// File: tb/tb_comparador_der_izq_serial.sv
// Scoreboard bench: N=8 directed vectors plus an exhaustive N=4 sweep.
module tb_comparador_der_izq_serial;
  typedef struct {
    logic [1:0] pq;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q8[$];
  exp_t q4[$];

  comparador_der_izq_serial_if #(.N(8)) b8 ();
  comparador_der_izq_serial_if #(.N(4)) b4 ();

  comparador_der_izq_serial #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  comparador_der_izq_serial #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (b8.busy_o && b8.done_o) begin
        errors++;
        $display("FAIL n8_busy_done_overlap busy=%0b done=%0b required not both", b8.busy_o, b8.done_o);
      end
      if (b8.done_o) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL n8_unexpected_done at cycle %0d pq=%b", cyc, {b8.p_o, b8.q_o});
        end else begin
          exp_t e;
          e = q8.pop_front();
          if ({b8.p_o, b8.q_o} !== e.pq || cyc != e.cyc) begin
            errors++;
            $display("FAIL n8_result pq=%b cycle=%0d required pq=%b cycle=%0d",
                     {b8.p_o, b8.q_o}, cyc, e.pq, e.cyc);
          end
        end
      end
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && b4.done_o) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL n4_unexpected_done at cycle %0d pq=%b", cyc, {b4.p_o, b4.q_o});
      end else begin
        exp_t e;
        e = q4.pop_front();
        if ({b4.p_o, b4.q_o} !== e.pq || cyc != e.cyc || (b4.p_o && b4.q_o) || b4.busy_o) begin
          errors++;
          $display("FAIL n4_result pq=%b cycle=%0d busy=%0b required pq=%b cycle=%0d busy=0",
                   {b4.p_o, b4.q_o}, cyc, b4.busy_o, e.pq, e.cyc);
        end
      end
    end
  end

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL n8_timeout pending=%0d required 0", q8.size());
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL n4_timeout pending=%0d required 0", q4.size());
      q4.delete();
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] pq);
    exp_t e;
    @(negedge clk);
    b8.start_i = 1'b1;
    b8.a_i     = a;
    b8.b_i     = b;
    e.pq = pq;
    e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    b8.start_i = 1'b0;
    b8.a_i     = 8'($urandom);
    b8.b_i     = 8'($urandom);
    drain8();
  endtask

  task automatic check_out8(input string name, input logic [3:0] req);
    logic [3:0] act;
    act = {b8.busy_o, b8.done_o, b8.p_o, b8.q_o};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s busy,done,p,q=%b required %b", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    cyc = 0;
    checks = 0;
    errors = 0;
    b8.start_i = 1'b0; b8.a_i = '0; b8.b_i = '0;
    b4.start_i = 1'b0; b4.a_i = '0; b4.b_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_out8("reset_n8", 4'b0000);
    checks++;
    if ({b4.busy_o, b4.done_o, b4.p_o, b4.q_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_n4 busy,done,p,q=%b required 0000", {b4.busy_o, b4.done_o, b4.p_o, b4.q_o});
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed N=8 vectors.
    op8(8'h00, 8'h00, 2'b00);
    op8(8'hA5, 8'hA5, 2'b00);
    op8(8'h81, 8'h80, 2'b10);
    check_out8("hold_after_done", 4'b0010);
    op8(8'h80, 8'h81, 2'b01);
    op8(8'h7F, 8'h80, 2'b01);
    op8(8'h80, 8'h7F, 2'b10);

    // start held through RUN with operands scrambled, back-to-back accept on DONE.
    @(negedge clk);
    b8.start_i = 1'b1;
    b8.a_i = 8'h3C; b8.b_i = 8'h3D;
    e.pq = 2'b01; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b8.a_i = 8'($urandom);
      b8.b_i = 8'($urandom);
    end
    @(negedge clk);
    b8.a_i = 8'hF0; b8.b_i = 8'h0F;
    e.pq = 2'b10; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    b8.start_i = 1'b0;
    b8.a_i = 8'h00; b8.b_i = 8'hFF;
    drain8();

    // Reset in the middle of a RUN.
    @(negedge clk);
    b8.start_i = 1'b1;
    b8.a_i = 8'h7F; b8.b_i = 8'h80;
    e.pq = 2'b01; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    b8.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check_out8("busy_before_reset", 4'b1010);
    rst_n = 1'b0;
    q8.delete();
    #1;
    check_out8("async_reset_clear", 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check_out8("no_resume_after_reset", 4'b0000);
    op8(8'h12, 8'h34, 2'b01);

    // Exhaustive N=4 sweep against the reference ordering.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        b4.start_i = 1'b1;
        b4.a_i = 4'(a);
        b4.b_i = 4'(b);
        e.pq = (a > b) ? 2'b10 : ((a < b) ? 2'b01 : 2'b00);
        e.cyc = cyc + 1 + 4;
        q4.push_back(e);
        @(negedge clk);
        b4.start_i = 1'b0;
        b4.a_i = 4'($urandom);
        b4.b_i = 4'($urandom);
        drain4();
      end
    end
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comparador_der_izq_serial.md
# comparador_der_izq_serial

Sequential magnitude comparator that scans two N-bit words A and B from right to left, LSB first, one bit pair per clock. It is the opposite scan direction of the combinational left-to-right iterative comparator network. It uses the same P/Q state encoding, so results from both implementations can be cross-checked bit for bit. It sits beside the iterative network as its area-reduced serial counterpart.

## Interface
- N, default 8, word width in bits; legal values are N ≥ 1.
- clk input 1: single clock; everything is sampled on the rising edge.
- rst_n input 1: asynchronous, active-low reset.
- start input 1: request to load A and B and begin a comparison.
- A input N: first operand, sampled only on the accepting edge.
- B input N: second operand, sampled only on the accepting edge.
- busy output 1: high while a comparison is in progress.
- done output 1: one-cycle pulse marking a valid result on P/Q.
- P output 1: result bit; 1 means A > B.
- Q output 1: result bit; 1 means A < B.
- P/Q encoding: 00 means equal, 10 means A > B, 01 means A < B, 11 is never produced.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Internal registers:
  - shift registers SA and SB, N bits each;
  - bit counter cnt, width $clog2(N)+1;
  - partial state PQs, 2 bits.
- IDLE, or DONE, with start=1 on an edge:
  - load SA←A and SB←B;
  - set PQs←00 and cnt←0;
  - go to RUN.
- RUN, on each edge:
  - examine the bit pair a=SA[0], b=SB[0];
  - a=1, b=0: PQs←10;
  - a=0, b=1: PQs←01;
  - a=b: PQs holds its value;
  - shift SA and SB right by one;
  - cnt←cnt+1.
- Right-to-left rule: a higher-order unequal pair overrides any lower-order decision. The final PQs therefore equals the decision of the most significant unequal bit pair.
- End of RUN: the edge that processes bit N-1 (cnt==N-1) goes to DONE. The same edge copies the updated partial state into the outputs, so P,Q ← final PQs.
- DONE:
  - lasts exactly one cycle;
  - start=1 is accepted exactly as in IDLE, which allows back-to-back operations;
  - with start=0 the FSM returns to IDLE.
- start while in RUN is ignored. A and B are not sampled again during RUN.
- P and Q are output registers, not the partial state. They change only on the edge that enters DONE. They hold their value through IDLE and through the RUN of the next comparison until that comparison completes.
- State 11 is unreachable. If the partial state is ever 11, the next RUN edge still applies the rules above, and the outputs are never driven to 11.

## Timing
- Reset: while rst_n=0, the FSM is in IDLE and busy=0, done=0, P=0, Q=0. SA, SB, cnt and PQs are all 0.
- Reset mid-operation aborts the comparison at once and asynchronously. The operation does not resume after reset is released.
- If start is accepted on edge k:
  - busy=1 from after edge k through after edge k+N-1;
  - on edge k+N the FSM enters DONE, busy=0, done=1 and P/Q are valid;
  - done falls after edge k+N+1.
- Latency is N cycles from the accepting edge to done.
- Throughput is one comparison every N+1 cycles. With start held high continuously, a new comparison is accepted on the DONE edge.
- N=1: RUN lasts a single cycle, and done is asserted 1 cycle after the accepting edge.
- busy and done are never high at the same time.

## Test plan
- Equal words, N=8: A=0x00, B=0x00, start pulsed → done 8 cycles later with PQ=00. Repeat with A=0xA5, B=0xA5 → PQ=00.
- LSB-only difference: A=0x81, B=0x80 → PQ=10. Then A=0x80, B=0x81 → PQ=01.
- MSB override: A=0x7F, B=0x80 → partial state is 10 during bits 0–6 and the final result is PQ=01. Then A=0x80, B=0x7F → PQ=10.
- Handshake: hold start=1 through the whole RUN while changing A/B mid-run → result matches the operands loaded at the accepting edge. A second operation starts on the DONE edge, and its done pulse comes N+1 cycles after the first done pulse.
- Reset mid-operation: assert rst_n=0 in cycle 4 of RUN → busy, done, P and Q all drop to 0 immediately. No done pulse appears after release, and a fresh start completes correctly.
- Exhaustive run with N=4:
  - all 256 (A,B) pairs, compared against the reference rule (A>B→10, A<B→01, otherwise 00);
  - check done latency = 4 on every operation;
  - check P/Q is never 11.
